// File: rtl/hit_flash_ctrl.sv
// Hit indicator: latches who scored, flashes the display border in frame-aligned
// ON/OFF pairs, holds off new hits through a cooldown and keeps saturating scores.
module hit_flash_ctrl #(
    parameter int          FLASH_FRAMES    = 4,
    parameter int          FLASH_COUNT     = 3,
    parameter int          COOLDOWN_FRAMES = 8,
    parameter logic [23:0] PLAYER_COLOR    = 24'h0000FF,
    parameter logic [23:0] OPP_COLOR       = 24'hFF0000,
    parameter logic [23:0] DRAW_COLOR      = 24'hFFFF00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        player_hit_in,
    input  logic        opponent_hit_in,
    input  logic        score_clear_in,
    output logic        border_en_out,
    output logic [23:0] border_color_out,
    output logic [3:0]  player_score_out,
    output logic [3:0]  opponent_score_out,
    output logic        busy_out
);

    // state    | meaning
    // IDLE     | waiting for a hit; only state in which hits are accepted
    // PEND     | owner latched, waiting for the next frame start
    // ON       | border lit with the owner colour
    // OFF      | border dark between flashes
    // COOLDOWN | border dark, hits still ignored

    localparam int MAX_A = (FLASH_FRAMES > FLASH_COUNT) ? FLASH_FRAMES : FLASH_COUNT;
    localparam int MAX_N = (MAX_A > COOLDOWN_FRAMES) ? MAX_A : COOLDOWN_FRAMES;
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_COUNT - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PEND, S_ON, S_OFF, S_COOLDOWN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PLAYER, OWN_OPP, OWN_DRAW} owner_t;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] flash_cnt;
    logic [23:0]      owner_color;
    logic             any_hit;

    assign any_hit = player_hit_in | opponent_hit_in;

    always_comb begin
        owner_color = 24'h000000;
        case (owner)
            OWN_PLAYER: owner_color = PLAYER_COLOR;
            OWN_OPP:    owner_color = OPP_COLOR;
            OWN_DRAW:   owner_color = DRAW_COLOR;
            default:    owner_color = 24'h000000;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= S_IDLE;
            owner              <= OWN_NONE;
            frame_cnt          <= '0;
            flash_cnt          <= '0;
            border_en_out      <= 1'b0;
            border_color_out   <= 24'h000000;
            player_score_out   <= 4'd0;
            opponent_score_out <= 4'd0;
            busy_out           <= 1'b0;
        end else begin
            // Clear takes priority over a score increment in the same cycle.
            if (score_clear_in) begin
                player_score_out   <= 4'd0;
                opponent_score_out <= 4'd0;
            end else if (state == S_IDLE) begin
                if (player_hit_in && !opponent_hit_in && player_score_out != 4'd15)
                    player_score_out <= player_score_out + 4'd1;
                if (opponent_hit_in && !player_hit_in && opponent_score_out != 4'd15)
                    opponent_score_out <= opponent_score_out + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    if (any_hit) begin
                        owner    <= (player_hit_in && opponent_hit_in) ? OWN_DRAW :
                                    player_hit_in ? OWN_PLAYER : OWN_OPP;
                        state    <= S_PEND;
                        busy_out <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (new_frame_in) begin
                        state            <= S_ON;
                        frame_cnt        <= '0;
                        flash_cnt        <= '0;
                        border_en_out    <= 1'b1;
                        border_color_out <= owner_color;
                    end
                end
                S_ON: begin
                    if (new_frame_in) begin
                        if (frame_cnt == FRAME_LAST) begin
                            state            <= S_OFF;
                            frame_cnt        <= '0;
                            border_en_out    <= 1'b0;
                            border_color_out <= 24'h000000;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_OFF: begin
                    if (new_frame_in) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            if (flash_cnt == FLASH_LAST) begin
                                state <= S_COOLDOWN;
                            end else begin
                                flash_cnt        <= flash_cnt + 1'b1;
                                state            <= S_ON;
                                border_en_out    <= 1'b1;
                                border_color_out <= owner_color;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (new_frame_in) begin
                        if (frame_cnt == COOL_LAST) begin
                            state     <= S_IDLE;
                            frame_cnt <= '0;
                            flash_cnt <= '0;
                            owner     <= OWN_NONE;
                            busy_out  <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_flash_ctrl.sv
// Scoreboard bench for hit_flash_ctrl: stimulus pushes expected outputs tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_hit_flash_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        new_frame_in = 1'b0;
    logic        player_hit_in = 1'b0;
    logic        opponent_hit_in = 1'b0;
    logic        score_clear_in = 1'b0;
    logic        border_en_out;
    logic [23:0] border_color_out;
    logic [3:0]  player_score_out;
    logic [3:0]  opponent_score_out;
    logic        busy_out;

    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;

    hit_flash_ctrl dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .new_frame_in       (new_frame_in),
        .player_hit_in      (player_hit_in),
        .opponent_hit_in    (opponent_hit_in),
        .score_clear_in     (score_clear_in),
        .border_en_out      (border_en_out),
        .border_color_out   (border_color_out),
        .player_score_out   (player_score_out),
        .opponent_score_out (opponent_score_out),
        .busy_out           (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        string       name;
        logic        en;
        logic [23:0] col;
        logic [3:0]  ps;
        logic [3:0]  os;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || border_en_out !== e.en || border_color_out !== e.col ||
                player_score_out !== e.ps || opponent_score_out !== e.os || busy_out !== e.busy) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d got en=%b col=%h ps=%0d os=%0d busy=%b want en=%b col=%h ps=%0d os=%0d busy=%b",
                         e.name, cyc, e.cyc, border_en_out, border_color_out, player_score_out,
                         opponent_score_out, busy_out, e.en, e.col, e.ps, e.os, e.busy);
            end
        end
    end

    task automatic step(input logic ph, input logic oh, input logic nf, input logic clr, input logic r);
        player_hit_in   = ph;
        opponent_hit_in = oh;
        new_frame_in    = nf;
        score_clear_in  = clr;
        rst_in          = r;
        @(posedge clk_in);
        #1;
        player_hit_in   = 1'b0;
        opponent_hit_in = 1'b0;
        new_frame_in    = 1'b0;
        score_clear_in  = 1'b0;
        rst_in          = 1'b0;
    endtask

    task automatic expect_now(input string n, input logic en, input logic [23:0] col,
                              input logic [3:0] ps, input logic [3:0] os, input logic busy);
        exp_t x;
        x.cyc = cyc; x.name = n; x.en = en; x.col = col; x.ps = ps; x.os = os; x.busy = busy;
        sb.push_back(x);
    endtask

    // Hand-derived timeline: ON during frames 1-4, 9-12, 17-20; busy through frame 32.
    function automatic logic on_frame(input int k);
        return (k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20);
    endfunction

    task automatic run_seq(input int first_k, input logic [23:0] col, input logic [3:0] ps,
                           input logic [3:0] os, input logic inj_opp);
        logic on;
        logic bz;
        for (int k = first_k; k <= 40; k++) begin
            step(0, 0, 1, 0, 0);
            on = on_frame(k);
            bz = (k <= 32);
            expect_now("frame", on, on ? col : 24'h0, ps, os, bz);
            step(0, 0, 0, 0, 0);
            expect_now("hold", on, on ? col : 24'h0, ps, os, bz);
            if (inj_opp && bz) begin
                step(0, 1, 0, 0, 0);
                expect_now("ignored_hit", on, on ? col : 24'h0, ps, os, bz);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got timeout want completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1, 1, 1, 1, 1);
        expect_now("reset", 0, 24'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        expect_now("reset2", 0, 24'h0, 0, 0, 0);

        step(1, 0, 0, 0, 0);
        expect_now("player_hit", 0, 24'h0, 1, 0, 1);
        run_seq(1, BLUE, 1, 0, 0);

        step(1, 1, 0, 0, 0);
        expect_now("draw_hit", 0, 24'h0, 1, 0, 1);
        run_seq(1, YELLOW, 1, 0, 0);

        step(0, 1, 0, 0, 0);
        expect_now("opp_hit", 0, 24'h0, 1, 1, 1);
        run_seq(1, RED, 1, 1, 1);

        step(0, 0, 0, 1, 0);
        expect_now("clear_idle", 0, 24'h0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 0);
            expect_now("sat_hit", 0, 24'h0, (i >= 14) ? 4'd15 : 4'(i + 1), 0, 1);
            for (int k = 1; k <= 33; k++) step(0, 0, 1, 0, 0);
            expect_now("sat_idle", 0, 24'h0, (i >= 14) ? 4'd15 : 4'(i + 1), 0, 0);
        end
        step(0, 0, 0, 1, 0);
        expect_now("clear_sat", 0, 24'h0, 0, 0, 0);

        step(1, 0, 0, 1, 0);
        expect_now("clear_with_hit", 0, 24'h0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        expect_now("on_after_clear_hit", 1, BLUE, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        expect_now("reset_mid_on", 0, 24'h0, 0, 0, 0);
        step(1, 0, 1, 0, 1);
        expect_now("hit_during_reset", 0, 24'h0, 0, 0, 0);

        step(1, 0, 1, 0, 0);
        expect_now("hit_with_frame", 0, 24'h0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        expect_now("pend_hold", 0, 24'h0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        expect_now("on_next_frame", 1, BLUE, 1, 0, 1);
        step(0, 0, 0, 1, 0);
        expect_now("clear_in_on", 1, BLUE, 0, 0, 1);
        run_seq(2, BLUE, 0, 0, 0);

        repeat (3) @(negedge clk_in);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
